// File: rtl/mbox_read_buffer.sv
// MBOX read buffer: FIFO of 36-bit fill words feeding the EBOX, plus a quad-word fill sequencer.
// Optional per-entry odd parity checking when MBOX_RDBUF_PARITY_EN is defined.
module mbox_read_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic        masterClk,
  input  logic        EBOX_RESET,
  input  logic        fillStart,
  input  logic [1:0]  fillWord,
  input  logic [2:0]  fillCount,
  input  logic        memValid,
  input  logic [0:35] memData,
  input  logic [1:0]  memWord,
`ifdef MBOX_RDBUF_PARITY_EN
  input  logic        memPar,
  output logic        parErr,
`endif
  output logic        memReady,
  output logic [0:35] cacheDataRead,
  output logic        rdValid,
  input  logic        rdTake,
  output logic        fillBusy,
  output logic        fillDone,
  output logic        seqErr
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [PTRW:0] FULL_CNT = (PTRW + 1)'(DEPTH);

  state_t          state;
  logic [0:35]     store [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW:0]   count;
  logic [1:0]      exp_word;
  logic [2:0]      remain;
  logic [2:0]      fill_total;
  logic            accept;
  logic            take;

  assign memReady      = (count != FULL_CNT);
  assign rdValid       = (count != '0);
  assign accept        = memValid && memReady;
  assign take          = rdTake && rdValid;
  assign cacheDataRead = rdValid ? store[rd_ptr] : '0;
  assign fillBusy      = (state == FILL);
  assign fill_total    = (fillCount == 3'd0) ? 3'd4 : fillCount;

  // NOTE: the storage array has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge masterClk) begin
    if (accept) store[wr_ptr] <= memData;
  end

`ifdef MBOX_RDBUF_PARITY_EN
  // Each entry keeps a "parity good" bit: odd parity over data plus memPar.
  logic par_ok [DEPTH];

  always_ff @(posedge masterClk) begin
    if (accept) par_ok[wr_ptr] <= ^{memData, memPar};
  end

  assign parErr = rdValid && !par_ok[rd_ptr];
`endif

  always_ff @(posedge masterClk) begin
    if (EBOX_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (take)   rd_ptr <= rd_ptr + 1'b1;
      case ({accept, take})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A word arriving in the same cycle as fillStart counts as the first word of that fill.
  always_ff @(posedge masterClk) begin
    if (EBOX_RESET) begin
      state    <= IDLE;
      exp_word <= '0;
      remain   <= '0;
      seqErr   <= 1'b0;
      fillDone <= 1'b0;
    end else begin
      fillDone <= 1'b0;
      case (state)
        IDLE: begin
          if (fillStart) begin
            if (accept) begin
              if (memWord != fillWord) seqErr <= 1'b1;
              exp_word <= fillWord + 2'd1;
              remain   <= fill_total - 3'd1;
              if (fill_total == 3'd1) fillDone <= 1'b1;
              else                    state    <= FILL;
            end else begin
              exp_word <= fillWord;
              remain   <= fill_total;
              state    <= FILL;
            end
          end else if (accept) begin
            seqErr <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            if (memWord != exp_word) seqErr <= 1'b1;
            exp_word <= exp_word + 2'd1;
            remain   <= remain - 3'd1;
            if (remain == 3'd1) begin
              fillDone <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
